// File: rtl/vic_pkg.sv
// Shared constants and types for the VIC-20 6560/6561 register file.
// Register indices, field bit positions, fixed read values and the decoded video config.
package vic_pkg;

    localparam logic [3:0] REG_HORIG    = 4'd0;
    localparam logic [3:0] REG_VORIG    = 4'd1;
    localparam logic [3:0] REG_COLS     = 4'd2;
    localparam logic [3:0] REG_ROWS     = 4'd3;
    localparam logic [3:0] REG_RASTER   = 4'd4;
    localparam logic [3:0] REG_BASE     = 4'd5;
    localparam logic [3:0] REG_LPEN_X   = 4'd6;
    localparam logic [3:0] REG_LPEN_Y   = 4'd7;
    localparam logic [3:0] REG_PADDLE_X = 4'd8;
    localparam logic [3:0] REG_PADDLE_Y = 4'd9;
    localparam logic [3:0] REG_BASS     = 4'd10;
    localparam logic [3:0] REG_ALTO     = 4'd11;
    localparam logic [3:0] REG_SOPRANO  = 4'd12;
    localparam logic [3:0] REG_NOISE    = 4'd13;
    localparam logic [3:0] REG_VOLUME   = 4'd14;
    localparam logic [3:0] REG_COLOR    = 4'd15;

    // Field bit positions inside the packed registers
    localparam int COLS_VA9_BIT    = 7;
    localparam int ROWS_CHAR16_BIT = 0;
    localparam int COLOR_INV_BIT   = 3;

    localparam logic [15:0] VIC_COLOR_RAM_BASE = 16'h9400;
    localparam logic [15:0] COLOR_RAM_VA9_OFS  = 16'h0200;

    localparam logic [7:0] LPEN_READ   = 8'h00;
    localparam logic [7:0] PADDLE_READ = 8'hFF;

    typedef logic [15:0][7:0] vic_regfile_t;

    // Everything the video stage consumes, in VIC address space
    typedef struct packed {
        logic [6:0]  xorigin;
        logic [7:0]  yorigin;
        logic [6:0]  cols;
        logic [6:0]  rows;
        logic        chars8x16;
        logic [13:0] screen_va;
        logic [13:0] char_va;
        logic        color_va9;
        logic [3:0]  aux_color;
        logic [3:0]  back_color;
        logic        inverted;
        logic [2:0]  border_color;
    } vic_video_cfg_t;

endpackage

// File: rtl/vic_addr_map.sv
// Maps a 14-bit VIC address onto the 16-bit CPU bus: VA13 selects between
// the $8000 block (VA13=0) and the $0000 block (VA13=1).
module vic_addr_map (
    input  logic [13:0] va,
    output logic [15:0] cpu_addr
);

    assign cpu_addr = {~va[13], 2'b00, va[12:0]};

endmodule

// File: rtl/vic_regs.sv
// VIC-20 6560/6561 CPU register file ($9000-$900F) with decoded video configuration.
// Optional frame-start shadowing of video outputs: define VIC_SHADOW_EN.
module vic_regs
    import vic_pkg::*;
#(
    parameter logic [15:0] COLOR_RAM_BASE = VIC_COLOR_RAM_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_cs,
    input  logic        cpu_we,
    input  logic [3:0]  cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    input  logic [7:0]  raster_line,
    output logic [6:0]  xorigin,
    output logic [7:0]  yorigin,
    output logic [6:0]  cols,
    output logic [6:0]  rows,
    output logic        chars8x16,
    output logic [15:0] screen_addr,
    output logic [15:0] char_rom_addr,
    output logic [15:0] color_ram_addr,
    output logic [3:0]  aux_color,
    output logic [3:0]  back_color,
    output logic        inverted,
    output logic [2:0]  border_color,
    output logic [39:0] sound_regs
);

    vic_regfile_t   regs_q, regs_d;
    logic [7:0]     cpu_dout_q, cpu_dout_d;
    logic [7:0]     rd_data;
    vic_video_cfg_t cfg_live;
    vic_video_cfg_t cfg;

    // Register writes; reg3 bit7 and the raster/light-pen/paddle slots are inputs, not storage
    always_comb begin
        regs_d = regs_q;
        if (cpu_cs && cpu_we) begin
            case (cpu_addr)
                REG_ROWS:     regs_d[REG_ROWS] = {1'b0, cpu_din[6:0]};
                REG_RASTER,
                REG_LPEN_X,
                REG_LPEN_Y,
                REG_PADDLE_X,
                REG_PADDLE_Y: ;
                default:      regs_d[cpu_addr] = cpu_din;
            endcase
        end
    end

    always_comb begin
        case (cpu_addr)
            REG_ROWS:     rd_data = {1'b0, regs_q[REG_ROWS][6:0]};
            REG_RASTER:   rd_data = raster_line;
            REG_LPEN_X,
            REG_LPEN_Y:   rd_data = LPEN_READ;
            REG_PADDLE_X,
            REG_PADDLE_Y: rd_data = PADDLE_READ;
            default:      rd_data = regs_q[cpu_addr];
        endcase
    end

    always_comb begin
        cpu_dout_d = cpu_dout_q;
        if (cpu_cs && !cpu_we) begin
            cpu_dout_d = rd_data;
        end
    end

    // NOTE: the register array is small and architecturally reset to zero, so it gets a
    // real reset; every flop in this block is written with <= so all of them sample together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q     <= '0;
            cpu_dout_q <= '0;
        end else begin
            regs_q     <= regs_d;
            cpu_dout_q <= cpu_dout_d;
        end
    end

    always_comb begin
        cfg_live              = '0;
        cfg_live.xorigin      = regs_q[REG_HORIG][6:0];
        cfg_live.yorigin      = regs_q[REG_VORIG];
        cfg_live.cols         = regs_q[REG_COLS][6:0];
        cfg_live.rows         = {1'b0, regs_q[REG_ROWS][6:1]};
        cfg_live.chars8x16    = regs_q[REG_ROWS][ROWS_CHAR16_BIT];
        cfg_live.screen_va    = {regs_q[REG_BASE][7:4], regs_q[REG_COLS][COLS_VA9_BIT], 9'b0};
        cfg_live.char_va      = {regs_q[REG_BASE][3:0], 10'b0};
        cfg_live.color_va9    = regs_q[REG_COLS][COLS_VA9_BIT];
        cfg_live.aux_color    = regs_q[REG_VOLUME][7:4];
        cfg_live.back_color   = regs_q[REG_COLOR][7:4];
        cfg_live.inverted     = regs_q[REG_COLOR][COLOR_INV_BIT];
        cfg_live.border_color = regs_q[REG_COLOR][2:0];
    end

`ifdef VIC_SHADOW_EN
    vic_video_cfg_t shadow_q, shadow_d;
    logic [7:0]     prev_line_q;
    logic           commit;

    // Commit on the edge where the raster enters line 0; cfg_live still reflects pre-edge regs
    always_comb begin
        commit   = (raster_line == 8'h00) && (prev_line_q != 8'h00);
        shadow_d = shadow_q;
        if (commit) begin
            shadow_d = cfg_live;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q    <= '0;
            prev_line_q <= '0;
        end else begin
            shadow_q    <= shadow_d;
            prev_line_q <= raster_line;
        end
    end

    assign cfg = shadow_q;
`else
    assign cfg = cfg_live;
`endif

    vic_addr_map u_screen_map (
        .va       (cfg.screen_va),
        .cpu_addr (screen_addr)
    );

    vic_addr_map u_char_map (
        .va       (cfg.char_va),
        .cpu_addr (char_rom_addr)
    );

    assign color_ram_addr = COLOR_RAM_BASE + (cfg.color_va9 ? COLOR_RAM_VA9_OFS : 16'h0000);

    assign cpu_dout     = cpu_dout_q;
    assign xorigin      = cfg.xorigin;
    assign yorigin      = cfg.yorigin;
    assign cols         = cfg.cols;
    assign rows         = cfg.rows;
    assign chars8x16    = cfg.chars8x16;
    assign aux_color    = cfg.aux_color;
    assign back_color   = cfg.back_color;
    assign inverted     = cfg.inverted;
    assign border_color = cfg.border_color;

    // Sound registers bypass the shadow so pitch/volume changes are immediate
    assign sound_regs = {4'b0000, regs_q[REG_VOLUME][3:0], regs_q[REG_NOISE],
                         regs_q[REG_SOPRANO], regs_q[REG_ALTO], regs_q[REG_BASS]};

endmodule

// File: tb/tb_vic_regs.sv
// Self-checking bench for vic_regs: directed scenarios plus randomized bus/raster traffic
// compared against a byte-array reference model (follows VIC_SHADOW_EN if defined).
module tb_vic_regs;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_cs, cpu_we;
    logic [3:0]  cpu_addr;
    logic [7:0]  cpu_din, cpu_dout, raster_line;
    logic [6:0]  xorigin, cols, rows;
    logic [7:0]  yorigin;
    logic        chars8x16, inverted;
    logic [15:0] screen_addr, char_rom_addr, color_ram_addr;
    logic [3:0]  aux_color, back_color;
    logic [2:0]  border_color;
    logic [39:0] sound_regs;

    always #5 clk = ~clk;

    vic_regs #(.COLOR_RAM_BASE(16'h9400)) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_cs         (cpu_cs),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_din        (cpu_din),
        .cpu_dout       (cpu_dout),
        .raster_line    (raster_line),
        .xorigin        (xorigin),
        .yorigin        (yorigin),
        .cols           (cols),
        .rows           (rows),
        .chars8x16      (chars8x16),
        .screen_addr    (screen_addr),
        .char_rom_addr  (char_rom_addr),
        .color_ram_addr (color_ram_addr),
        .aux_color      (aux_color),
        .back_color     (back_color),
        .inverted       (inverted),
        .border_color   (border_color),
        .sound_regs     (sound_regs)
    );

    // Reference model: CPU-visible bytes, the bytes currently driving video, last raster, read data
    int         m_regs[16];
    int         m_vis[16];
    int         m_prev;
    int         m_dout;
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_read(input int a, input int rl);
        case (a)
            3:       return m_regs[3] % 128;
            4:       return rl;
            6, 7:    return 0;
            8, 9:    return 255;
            default: return m_regs[a];
        endcase
    endfunction

    function automatic int va_to_cpu(input int va);
        return (va >= 8192) ? va - 8192 : va + 32768;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_regs[i] = 0;
            m_vis[i]  = 0;
        end
        m_prev = 0;
        m_dout = 0;
    endtask

    task automatic check_outputs();
        int va_scr;
        va_scr = (m_vis[5] / 16) * 1024 + (m_vis[2] / 128) * 512;
        check("cpu_dout", 64'(cpu_dout), 64'(m_dout));
        check("xorigin", 64'(xorigin), 64'(m_vis[0] % 128));
        check("yorigin", 64'(yorigin), 64'(m_vis[1]));
        check("cols", 64'(cols), 64'(m_vis[2] % 128));
        check("rows", 64'(rows), 64'((m_vis[3] % 128) / 2));
        check("chars8x16", 64'(chars8x16), 64'(m_vis[3] % 2));
        check("screen_addr", 64'(screen_addr), 64'(va_to_cpu(va_scr)));
        check("char_rom_addr", 64'(char_rom_addr), 64'(va_to_cpu((m_vis[5] % 16) * 1024)));
        check("color_ram_addr", 64'(color_ram_addr), 64'(32'h9400 + (m_vis[2] / 128) * 512));
        check("aux_color", 64'(aux_color), 64'(m_vis[14] / 16));
        check("back_color", 64'(back_color), 64'(m_vis[15] / 16));
        check("inverted", 64'(inverted), 64'((m_vis[15] / 8) % 2));
        check("border_color", 64'(border_color), 64'(m_vis[15] % 8));
        check("sound_regs", 64'(sound_regs),
              (64'(m_regs[14] % 16) << 32) | (64'(m_regs[13]) << 24) | (64'(m_regs[12]) << 16)
              | (64'(m_regs[11]) << 8) | 64'(m_regs[10]));
    endtask

    // One bus cycle: drive, clock, advance the model with pre-edge state, then compare
    task automatic cycle(input logic cs, input logic we, input logic [3:0] addr,
                         input logic [7:0] din, input logic [7:0] rl);
`ifdef VIC_SHADOW_EN
        bit commit;
        commit = (int'(rl) == 0) && (m_prev != 0);
`endif
        cpu_cs      = cs;
        cpu_we      = we;
        cpu_addr    = addr;
        cpu_din     = din;
        raster_line = rl;
        @(posedge clk);
`ifdef VIC_SHADOW_EN
        if (commit) m_vis = m_regs;
`endif
        if (cs && !we) m_dout = model_read(int'(addr), int'(rl));
        if (cs && we && addr != 4'd4) m_regs[addr] = (addr == 4'd3) ? int'(din) % 128 : int'(din);
`ifndef VIC_SHADOW_EN
        m_vis = m_regs;
`endif
        m_prev = int'(rl);
        #1;
        check_outputs();
    endtask

    task automatic random_cycles(input int n);
        logic [7:0] rl;
        for (int i = 0; i < n; i++) begin
            rl = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), rl);
        end
    endtask

    initial begin
        reset = 1'b1; cpu_cs = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0; raster_line = '0;
        model_reset();
        #12;
        reset = 1'b0;
        #1;
        check_outputs();
        check("rst_screen", 64'(screen_addr), 64'h8000);
        check("rst_color", 64'(color_ram_addr), 64'h9400);

        // Bases: screen at $1E00, colour RAM at $9600
        cycle(1, 1, 4'h5, 8'hF0, 8'h82);
        cycle(1, 1, 4'h2, 8'h96, 8'h82);
        cycle(0, 0, 4'h0, 8'h00, 8'h82);
        cycle(0, 0, 4'h0, 8'h00, 8'h00);
        check("t2_screen", 64'(screen_addr), 64'h1E00);
        check("t2_color", 64'(color_ram_addr), 64'h9600);
        check("t2_char", 64'(char_rom_addr), 64'h8000);
        check("t2_cols", 64'(cols), 64'd22);

        // Colour register held until frame start
        cycle(1, 1, 4'hF, 8'h1B, 8'h40);
        cycle(0, 0, 4'h0, 8'h00, 8'h40);
`ifdef VIC_SHADOW_EN
        check("t3_border_held", 64'(border_color), 64'd0);
`endif
        cycle(0, 0, 4'h0, 8'h00, 8'h00);
        check("t3_border", 64'(border_color), 64'd3);
        check("t3_inverted", 64'(inverted), 64'd1);
        check("t3_back", 64'(back_color), 64'd1);

        // Raster and paddle reads; reg4 ignores writes
        cycle(1, 0, 4'h4, 8'h00, 8'h5A);
        check("t4_raster", 64'(cpu_dout), 64'h5A);
        cycle(1, 0, 4'h8, 8'h00, 8'h5A);
        check("t4_paddle", 64'(cpu_dout), 64'hFF);
        cycle(1, 1, 4'h4, 8'h00, 8'h5A);
        cycle(0, 0, 4'h0, 8'h00, 8'h5A);
        check("t4_hold", 64'(cpu_dout), 64'hFF);
        cycle(1, 0, 4'h4, 8'h00, 8'h5A);
        check("t4_raster2", 64'(cpu_dout), 64'h5A);

        // Write coinciding with commit lands one frame late
        cycle(0, 0, 4'h0, 8'h00, 8'h10);
        cycle(1, 1, 4'h3, 8'h2F, 8'h00);
`ifdef VIC_SHADOW_EN
        check("t5_rows_held", 64'(rows), 64'd0);
        check("t5_c16_held", 64'(chars8x16), 64'd0);
`endif
        cycle(0, 0, 4'h0, 8'h00, 8'h10);
        cycle(0, 0, 4'h0, 8'h00, 8'h00);
        check("t5_rows", 64'(rows), 64'd23);
        check("t5_c16", 64'(chars8x16), 64'd1);
        cycle(1, 0, 4'h3, 8'h00, 8'h10);
        check("t5_read3", 64'(cpu_dout), 64'h2F);

        // Sound registers immediate, aux colour at next frame
        cycle(1, 1, 4'hA, 8'h80, 8'h10);
        cycle(1, 1, 4'hE, 8'h3F, 8'h10);
        check("t6_sound_lo", 64'(sound_regs[7:0]), 64'h80);
        check("t6_sound_hi", 64'(sound_regs[39:32]), 64'h0F);
        cycle(0, 0, 4'h0, 8'h00, 8'h00);
        check("t6_aux", 64'(aux_color), 64'd3);

        random_cycles(400);

        // Asynchronous reset in the middle of a cycle
        cycle(1, 1, 4'h5, 8'hF0, 8'h33);
        cycle(1, 1, 4'h2, 8'hFF, 8'h33);
        cycle(1, 0, 4'h2, 8'h00, 8'h00);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("t1_screen", 64'(screen_addr), 64'h8000);
        check("t1_color", 64'(color_ram_addr), 64'h9400);
        check("t1_dout", 64'(cpu_dout), 64'h00);
        check_outputs();
        cpu_cs = 1'b0;
        @(posedge clk);
        #3;
        reset = 1'b0;

        random_cycles(300);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
